// File: rtl/conv_pool_mc_pkg.sv
// Shared types and helpers for the multi-channel conv/pool engine:
// FSM states, pool-mode encoding, accumulator sizing and output saturation.
package conv_pool_pkg;

   typedef enum logic [1:0] {IDLE, CONV, POOL, WRITE} state_t;

   localparam logic POOL_MAX = 1'b0;
   localparam logic POOL_AVG = 1'b1;
   localparam int   SAT_W    = 64;

   function automatic int acc_w(input int dw, input int kw);
      return dw + kw + 5;
   endfunction

   // Clamp to the unsigned range when relu_en, else to the signed range; the
   // caller keeps the low dw bits of the result.
   function automatic logic [31:0] sat(input logic signed [SAT_W-1:0] acc,
                                       input logic relu_en, input int dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] r;
      if (relu_en) begin
         hi = (64'sd1 <<< dw) - 64'sd1;
         lo = 64'sd0;
      end else begin
         hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
         lo = -(64'sd1 <<< (dw - 1));
      end
      r = (acc > hi) ? hi : ((acc < lo) ? lo : acc);
      return r[31:0];
   endfunction

endpackage

// File: rtl/conv_pool_mc_if.sv
// Tile-in / result-out bundle of conv_pool_mc: master drives tiles and config,
// slave (the engine) returns in_ready, per-channel write strobes, results and overrun.
interface conv_pool_mc_if #(
   parameter int N_CH = 3,
   parameter int DW   = 8,
   parameter int KW   = 8,
   parameter int AW   = 16,
   parameter int SHW  = 2
);
   logic [16*DW-1:0]     image_4x4;
   logic [N_CH*9*KW-1:0] conv_kernel;
   logic [SHW-1:0]       shift;
   logic                 pool_mode;
   logic                 relu_en;
   logic [N_CH-1:0]      ch_en;
   logic                 input_re;
   logic [AW-1:0]        input_addr;
   logic                 in_ready;
   logic [N_CH-1:0]      output_we;
   logic [AW-1:0]        output_addr;
   logic [N_CH*DW-1:0]   y;
   logic                 overrun;

   modport master (
      output image_4x4, conv_kernel, shift, pool_mode, relu_en, ch_en, input_re, input_addr,
      input  in_ready, output_we, output_addr, y, overrun
   );

   modport slave (
      input  image_4x4, conv_kernel, shift, pool_mode, relu_en, ch_en, input_re, input_addr,
      output in_ready, output_we, output_addr, y, overrun
   );
endinterface

// File: rtl/conv9_mac.sv
// Combinational 9-tap dot product of one 3x3 window (selected by pos) of a 4x4 tile.
// Pixels are unsigned, taps signed; zero latency, no flow control.
module conv9_mac #(
   parameter int DW    = 8,
   parameter int KW    = 8,
   parameter int ACC_W = 21
) (
   input  logic [16*DW-1:0]       tile,
   input  logic [9*KW-1:0]        kern,
   input  logic [1:0]             pos,
   output logic signed [ACC_W-1:0] acc
);
   logic signed [ACC_W-1:0] px;
   logic signed [ACC_W-1:0] kx;

   // pos[1] is the output row, pos[0] the output column.
   always_comb begin
      acc = '0;
      px  = '0;
      kx  = '0;
      for (int kr = 0; kr < 3; kr++) begin
         for (int kc = 0; kc < 3; kc++) begin
            px  = {{(ACC_W-DW){1'b0}},
                   tile[((int'(pos[1]) + kr) * 4 + int'(pos[0]) + kc) * DW +: DW]};
            kx  = {{(ACC_W-KW){kern[(kr*3+kc)*KW + KW - 1]}}, kern[(kr*3+kc)*KW +: KW]};
            acc = acc + px * kx;
         end
      end
   end
endmodule

// File: rtl/conv_pool_mc.sv
// Multi-channel 4x4 conv -> 2x2 pool -> requantise engine; 6 cycles accept-to-write edge.
// in_ready only in IDLE/WRITE; tiles offered while busy are dropped and flag sticky overrun.
module conv_pool_mc #(
   parameter int N_CH = 3,
   parameter int DW   = 8,
   parameter int KW   = 8,
   parameter int AW   = 16,
   parameter int SHW  = 2
) (
   input  logic clk,
   input  logic rst,
   conv_pool_mc_if.slave bus
);
   import conv_pool_pkg::*;

   localparam int ACC_W  = acc_w(DW, KW);
   localparam int POOL_W = ACC_W + 2;

   typedef struct packed {
      logic [SHW-1:0]  shift;
      logic            pool_mode;
      logic            relu_en;
      logic [N_CH-1:0] ch_en;
      logic [AW-1:0]   addr;
   } cfg_t;

   state_t                  st;
   state_t                  st_n;
   logic [1:0]              pos;
   logic [16*DW-1:0]        tile;
   logic [N_CH*9*KW-1:0]    kern;
   cfg_t                    cfg;
   logic signed [ACC_W-1:0] mac [N_CH];
   logic signed [ACC_W-1:0] acc [N_CH][4];
   logic [N_CH*DW-1:0]      y_n;
   logic [N_CH*DW-1:0]      y_q;
   logic [N_CH-1:0]         we_q;
   logic [AW-1:0]           oaddr_q;
   logic                    ovr_q;
   logic                    ready;
   logic                    accept;

   assign ready  = (st == IDLE) || (st == WRITE);
   assign accept = bus.input_re && ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= IDLE;
      else      st <= st_n;
   end

   always_comb begin
      st_n = st;
      case (st)
         IDLE:    if (accept) st_n = CONV;
         CONV:    if (pos == 2'd3) st_n = POOL;
         POOL:    st_n = WRITE;
         WRITE:   st_n = accept ? CONV : IDLE;
         default: st_n = IDLE;
      endcase
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_mac
      conv9_mac #(.DW(DW), .KW(KW), .ACC_W(ACC_W)) u_mac (
         .tile (tile),
         .kern (kern[g*9*KW +: 9*KW]),
         .pos  (pos),
         .acc  (mac[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos     <= '0;
         tile    <= '0;
         kern    <= '0;
         cfg     <= '0;
         we_q    <= '0;
         oaddr_q <= '0;
         y_q     <= '0;
         ovr_q   <= 1'b0;
         for (int ch = 0; ch < N_CH; ch++)
            for (int p = 0; p < 4; p++)
               acc[ch][p] <= '0;
      end else begin
         we_q <= '0;
         if (bus.input_re && !ready) ovr_q <= 1'b1;
         if (accept) begin
            tile <= bus.image_4x4;
            kern <= bus.conv_kernel;
            cfg  <= '{shift: bus.shift, pool_mode: bus.pool_mode, relu_en: bus.relu_en,
                      ch_en: bus.ch_en, addr: bus.input_addr};
            pos  <= '0;
         end else if (st == CONV) begin
            for (int ch = 0; ch < N_CH; ch++) acc[ch][pos] <= mac[ch];
            pos <= pos + 2'd1;
         end
         if (st == POOL) begin
            we_q    <= cfg.ch_en;
            oaddr_q <= cfg.addr;
            y_q     <= y_n;
         end
      end
   end

   logic signed [POOL_W-1:0] e [4];
   logic signed [POOL_W-1:0] mx;
   logic signed [POOL_W-1:0] sm;
   logic signed [POOL_W-1:0] pl;
   logic [31:0]              s;

   // Pool in POOL_W bits so the 4-way sum cannot wrap before the floor divide.
   always_comb begin
      y_n = '0;
      for (int p = 0; p < 4; p++) e[p] = '0;
      mx = '0;
      sm = '0;
      pl = '0;
      s  = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         for (int p = 0; p < 4; p++) e[p] = {{2{acc[ch][p][ACC_W-1]}}, acc[ch][p]};
         mx = e[0];
         for (int p = 1; p < 4; p++) if (e[p] > mx) mx = e[p];
         sm = e[0] + e[1] + e[2] + e[3];
         pl = (cfg.pool_mode == POOL_AVG) ? (sm >>> 2) : mx;
         pl = pl >>> cfg.shift;
         s  = sat({{(SAT_W-POOL_W){pl[POOL_W-1]}}, pl}, cfg.relu_en, DW);
         y_n[ch*DW +: DW] = s[DW-1:0];
      end
   end

   assign bus.in_ready    = ready;
   assign bus.output_we   = we_q;
   assign bus.output_addr = oaddr_q;
   assign bus.y           = y_q;
   assign bus.overrun     = ovr_q;
endmodule
